if_id_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.

---
 rtl/mips_defs_pkg.sv | 27 ++
 rtl/if_id_stage_pc_register.sv | 23 ++
 rtl/if_id_stage.sv | 110 +++++++++++
 tb/tb_if_id_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS core definitions: widths, opcodes, NOP encoding, reset PC and IF/ID payload.
package mips_defs_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_JUMP  = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc4;
        logic               valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

endpackage

// File: rtl/if_id_stage_pc_register.sv
// Program counter register with asynchronous reset to a fixed PC and a load enable.
module pc_register
    import mips_defs_pkg::*;
#(
    parameter int unsigned       ADDR_W   = mips_defs_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] next_pc_i,
    output logic [ADDR_W-1:0] pc_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o <= RESET_PC;
        end else if (load_i) begin
            pc_o <= next_pc_i;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register: next-PC selection, redirects,
// hazard stalls/flushes, decoded field slices and a fetched-instruction counter.
module if_id_stage
    import mips_defs_pkg::*;
#(
    parameter int unsigned       ADDR_W   = mips_defs_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = mips_defs_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               jump_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  id_pc4_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic               id_valid_o,
    output logic [5:0]         op_o,
    output logic [4:0]         rs_o,
    output logic [4:0]         rt_o,
    output logic [4:0]         rd_o,
    output logic [15:0]        imm_o,
    output logic [5:0]         funct_o,
    output logic [31:0]        fetch_count_o
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] jump_target;
    logic              pc_load;
    logic              ifid_load;
    logic              bubble;
    logic              count_inc;
    if_id_t            ifid_q;
    if_id_t            ifid_d;
    logic [31:0]       count_q;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (pc_load),
        .next_pc_i (next_pc),
        .pc_o      (pc)
    );

    assign pc4         = pc + ADDR_W'(4);
    assign jump_target = {ifid_q.pc4[ADDR_W-1:28], ifid_q.instr[25:0], 2'b00};

    // Redirects outrank stalls; a jump in a bubble slot never redirects.
    always_comb begin
        next_pc   = pc4;
        pc_load   = 1'b1;
        ifid_load = 1'b1;
        bubble    = 1'b0;
        count_inc = 1'b0;
        if (branch_taken_i) begin
            next_pc = {branch_target_i[ADDR_W-1:2], 2'b00};
            bubble  = 1'b1;
        end else if (jump_i && ifid_q.valid) begin
            next_pc = jump_target;
            bubble  = 1'b1;
        end else if (stall_i) begin
            pc_load   = 1'b0;
            ifid_load = 1'b0;
        end else if (flush_i) begin
            bubble = 1'b1;
        end else begin
            count_inc = 1'b1;
        end
        ifid_d = bubble ? IF_ID_BUBBLE : '{instr: imem_data_i, pc4: pc4, valid: 1'b1};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_q  <= IF_ID_BUBBLE;
            count_q <= '0;
        end else begin
            if (ifid_load) begin
                ifid_q <= ifid_d;
            end
            if (count_inc) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign pc_o          = pc;
    assign imem_addr_o   = pc;
    assign id_pc4_o      = ifid_q.pc4;
    assign id_instr_o    = ifid_q.instr;
    assign id_valid_o    = ifid_q.valid;
    assign fetch_count_o = count_q;

    assign op_o    = ifid_q.instr[31:26];
    assign rs_o    = ifid_q.instr[25:21];
    assign rt_o    = ifid_q.instr[20:16];
    assign rd_o    = ifid_q.instr[15:11];
    assign imm_o   = ifid_q.instr[15:0];
    assign funct_o = ifid_q.instr[5:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed scenarios plus random traffic against a cycle model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        stall_i, flush_i, branch_taken_i, jump_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o, id_pc4_o, id_instr_o, fetch_count_o;
    logic        id_valid_o;
    logic [5:0]  op_o, funct_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic [15:0] imm_o;

    if_id_stage dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .pc_o            (pc_o),
        .id_pc4_o        (id_pc4_o),
        .id_instr_o      (id_instr_o),
        .id_valid_o      (id_valid_o),
        .op_o            (op_o),
        .rs_o            (rs_o),
        .rt_o            (rt_o),
        .rd_o            (rd_o),
        .imm_o           (imm_o),
        .funct_o         (funct_o),
        .fetch_count_o   (fetch_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem[logic [31:0]];

    // Reference state of the fetch stage
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    endtask

    task automatic check_reset_values();
        check("rst_pc", pc_o, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_instr", id_instr_o, 32'h0);
        check("rst_pc4", id_pc4_o, 32'h0);
        check("rst_valid", 32'(id_valid_o), 32'h0);
        check("rst_count", fetch_count_o, 32'h0);
    endtask

    // Apply one cycle of inputs (no waiting), advance the model, queue the expected result.
    task automatic drive(input logic br, input logic [31:0] tgt, input logic jmp,
                         input logic stl, input logic fl);
        logic [31:0] fetched;
        exp_t e;
        branch_taken_i  = br;
        branch_target_i = tgt;
        jump_i          = jmp;
        stall_i         = stl;
        flush_i         = fl;
        imem_data_i     = imem_word(imem_addr_o);
        fetched         = imem_word(m_pc);
        if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (jmp && m_valid) begin
            m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (stl) begin
            // everything holds
        end else if (fl) begin
            m_pc = m_pc + 4;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else begin
            m_instr = fetched; m_pc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4;
            m_count = m_count + 1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.count = m_count;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic br, input logic [31:0] tgt, input logic jmp,
                        input logic stl, input logic fl);
        @(negedge clk);
        drive(br, tgt, jmp, stl, fl);
    endtask

    // Monitor: compare DUT state against the next queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_i && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc_o, e.pc);
                check("imem_addr", imem_addr_o, e.pc);
                check("id_instr", id_instr_o, e.instr);
                check("id_pc4", id_pc4_o, e.pc4);
                check("id_valid", 32'(id_valid_o), 32'(e.valid));
                check("fetch_count", fetch_count_o, e.count);
                check("op", 32'(op_o), 32'(e.instr[31:26]));
                check("rs", 32'(rs_o), 32'(e.instr[25:21]));
                check("rt", 32'(rt_o), 32'(e.instr[20:16]));
                check("rd", 32'(rd_o), 32'(e.instr[15:11]));
                check("imm", 32'(imm_o), 32'(e.instr[15:0]));
                check("funct", 32'(funct_o), 32'(e.instr[5:0]));
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0;
        branch_target_i = 0; imem_data_i = 0;
        mem[32'h0000_0000] = 32'h2008_0005;
        mem[32'h1000_0004] = 32'h0800_0010;
        model_reset();
        #1;
        check_reset_values();

        // Reset release and first fetch
        @(negedge clk);
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        // Stall three edges at pc 8, then resume
        step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Branch beats a simultaneous stall
        step(1, 32'h40, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Jump from a latched j instruction, then jump ignored on the bubble
        step(1, 32'h1000_0004, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        // Branch with misaligned target, then PC wrap
        step(1, 32'hFFFF_FFFF, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Flush, then branch and jump together
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 32'h0000_0200, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) == 0,
                 $urandom,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset in the middle of a stall
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
